// File: rtl/stream_idle_scheduler_pkg.sv
// Shared types and constants for the stream idle scheduler.
// Optional frame counter feature: STREAM_SCHED_FRAME_CNT_EN.
package iso_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VBLANK,
    HBLANK,
    HACTIVE
  } sched_state_t;

  localparam logic [1:0] SEL_ACTIVE = 2'b10;
  localparam logic [1:0] SEL_BLANK  = 2'b01;
  localparam logic [1:0] SEL_IDLE   = 2'b00;

  localparam int MIN_H_BLANK = 4;

endpackage

// File: rtl/stream_idle_scheduler_if.sv
// Config, status and mux-select bundle between link policy and scheduler.
// STREAM_SCHED_FRAME_CNT_EN adds sched_frame_cnt.
interface stream_idle_scheduler_if #(
  parameter int H_W = 16,
  parameter int V_W = 13
);

  logic           cfg_stream_en;
  logic [H_W-1:0] cfg_h_active;
  logic [H_W-1:0] cfg_h_blank;
  logic [V_W-1:0] cfg_v_active;
  logic [V_W-1:0] cfg_v_blank;
  logic           active_fifo_empty;

  logic [1:0]     sched_stream_idle_sel;
  logic           sched_blank_start;
  logic           sched_active_start;
  logic           sched_vblank_flag;
  logic           sched_frame_start;
  logic           sched_cfg_err;
  logic           sched_underflow_err;
`ifdef STREAM_SCHED_FRAME_CNT_EN
  logic [15:0]    sched_frame_cnt;
`endif

  // scheduler side
  modport master (
    input  cfg_stream_en,
    input  cfg_h_active,
    input  cfg_h_blank,
    input  cfg_v_active,
    input  cfg_v_blank,
    input  active_fifo_empty,
    output sched_stream_idle_sel,
    output sched_blank_start,
    output sched_active_start,
    output sched_vblank_flag,
    output sched_frame_start,
`ifdef STREAM_SCHED_FRAME_CNT_EN
    output sched_frame_cnt,
`endif
    output sched_cfg_err,
    output sched_underflow_err
  );

  // policy / mux side
  modport slave (
    output cfg_stream_en,
    output cfg_h_active,
    output cfg_h_blank,
    output cfg_v_active,
    output cfg_v_blank,
    output active_fifo_empty,
    input  sched_stream_idle_sel,
    input  sched_blank_start,
    input  sched_active_start,
    input  sched_vblank_flag,
    input  sched_frame_start,
`ifdef STREAM_SCHED_FRAME_CNT_EN
    input  sched_frame_cnt,
`endif
    input  sched_cfg_err,
    input  sched_underflow_err
  );

endinterface

// File: rtl/stream_idle_scheduler_timing_cnt.sv
// Horizontal symbol and vertical line counters for the scheduler.
// Both wrap to 0 at their terminal count (len-1); no feature macros.
module iso_sched_timing_cnt #(
  parameter int H_W = 16,
  parameter int V_W = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clr,
  input  logic           i_h_en,
  input  logic           i_v_en,
  input  logic [H_W-1:0] i_h_len,
  input  logic [V_W-1:0] i_v_len,
  output logic           o_h_tc,
  output logic           o_v_tc
);

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;

  // compare to len-1 so an all-ones length never needs an extra bit
  assign o_h_tc = (r_h_cnt == i_h_len - H_W'(1));
  assign o_v_tc = (r_v_cnt == i_v_len - V_W'(1));

  // symbol counter within the current segment
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_h_cnt <= '0;
    end else if (i_h_en) begin
      r_h_cnt <= o_h_tc ? '0 : r_h_cnt + H_W'(1);
    end
  end

  // line counter within the current region
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_v_cnt <= '0;
    end else if (i_v_en) begin
      r_v_cnt <= o_v_tc ? '0 : r_v_cnt + V_W'(1);
    end
  end

endmodule

// File: rtl/stream_idle_scheduler.sv
// Per-lane frame sequencer driving the stream idle mux select.
// STREAM_SCHED_FRAME_CNT_EN adds a 16-bit frame counter output.
module stream_idle_scheduler
  import iso_sched_pkg::*;
#(
  parameter int H_W = 16,
  parameter int V_W = 13
) (
  input logic                     clk,
  input logic                     rst,
  stream_idle_scheduler_if.master bus
);

  sched_state_t   r_state;
  logic           r_vb_ph;
  logic [H_W-1:0] r_sh_ha;
  logic [H_W-1:0] r_sh_hb;
  logic [V_W-1:0] r_sh_va;
  logic [V_W-1:0] r_sh_vb;

  logic [1:0]     r_sel;
  logic           r_bs;
  logic           r_as;
  logic           r_vf;
  logic           r_fs;
  logic           r_cfg_err;
  logic           r_unf;

  sched_state_t   w_nxt_state;
  logic           w_nxt_ph;
  logic [1:0]     w_nxt_sel;
  logic           w_latch;
  logic           w_frame;
  logic           w_bstart;
  logic           w_astart;
  logic           w_cfg_bad;
  logic           w_cfg_good;
  logic           w_h_en;
  logic           w_v_en;
  logic           w_h_tc;
  logic           w_v_tc;
  logic           w_clr;
  logic           w_cfg_ok;
  logic           w_en;
  logic [H_W-1:0] w_h_len;
  logic [V_W-1:0] w_v_len;

  assign w_en = bus.cfg_stream_en;

  assign w_cfg_ok =
    (bus.cfg_h_active != '0) &&
    (bus.cfg_h_blank >= H_W'(MIN_H_BLANK)) &&
    (bus.cfg_v_active != '0) &&
    (bus.cfg_v_blank != '0);

  assign w_clr = (r_state == IDLE);

  // a VBLANK line is counted as blank part then active part,
  // so its length never exceeds one H_W counter
  always_comb begin
    w_h_len = r_sh_hb;
    if (r_state == HACTIVE) w_h_len = r_sh_ha;
    if (r_state == VBLANK && r_vb_ph) w_h_len = r_sh_ha;
    w_v_len = (r_state == VBLANK) ? r_sh_vb : r_sh_va;
  end

  iso_sched_timing_cnt #(
    .H_W (H_W),
    .V_W (V_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_h_en  (w_h_en),
    .i_v_en  (w_v_en),
    .i_h_len (w_h_len),
    .i_v_len (w_v_len),
    .o_h_tc  (w_h_tc),
    .o_v_tc  (w_v_tc)
  );

  // next-state decode; enable is honoured only at line boundaries
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ph    = r_vb_ph;
    w_latch     = 1'b0;
    w_frame     = 1'b0;
    w_bstart    = 1'b0;
    w_astart    = 1'b0;
    w_cfg_bad   = 1'b0;
    w_h_en      = 1'b0;
    w_v_en      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_en) begin
          w_latch = 1'b1;
          if (w_cfg_ok) begin
            w_nxt_state = VBLANK;
            w_frame     = 1'b1;
            w_bstart    = 1'b1;
          end else begin
            w_cfg_bad = 1'b1;
          end
        end
      end
      VBLANK: begin
        w_h_en = 1'b1;
        if (w_h_tc) begin
          if (!r_vb_ph) begin
            w_nxt_ph = 1'b1;
          end else begin
            w_nxt_ph = 1'b0;
            w_v_en   = 1'b1;
            if (!w_en) begin
              w_nxt_state = IDLE;
            end else begin
              w_bstart = 1'b1;
              if (w_v_tc) w_nxt_state = HBLANK;
            end
          end
        end
      end
      HBLANK: begin
        w_h_en = 1'b1;
        if (w_h_tc) begin
          w_nxt_state = HACTIVE;
          w_astart    = 1'b1;
        end
      end
      HACTIVE: begin
        w_h_en = 1'b1;
        if (w_h_tc) begin
          w_v_en = 1'b1;
          if (!w_en) begin
            w_nxt_state = IDLE;
          end else if (w_v_tc) begin
            w_latch = 1'b1;
            if (w_cfg_ok) begin
              w_nxt_state = VBLANK;
              w_frame     = 1'b1;
              w_bstart    = 1'b1;
            end else begin
              w_nxt_state = IDLE;
              w_cfg_bad   = 1'b1;
            end
          end else begin
            w_nxt_state = HBLANK;
            w_bstart    = 1'b1;
          end
        end
      end
    endcase
  end

  assign w_cfg_good = w_latch && w_cfg_ok;

  // mux select that goes with the next state
  always_comb begin
    w_nxt_sel = SEL_IDLE;
    unique case (w_nxt_state)
      IDLE:    w_nxt_sel = SEL_IDLE;
      VBLANK:  w_nxt_sel = SEL_BLANK;
      HBLANK:  w_nxt_sel = SEL_BLANK;
      HACTIVE: w_nxt_sel = SEL_ACTIVE;
    endcase
  end

  // state, shadow config and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_vb_ph   <= 1'b0;
      r_sh_ha   <= '0;
      r_sh_hb   <= '0;
      r_sh_va   <= '0;
      r_sh_vb   <= '0;
      r_sel     <= SEL_IDLE;
      r_bs      <= 1'b0;
      r_as      <= 1'b0;
      r_vf      <= 1'b0;
      r_fs      <= 1'b0;
      r_cfg_err <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_vb_ph <= w_nxt_ph;
      if (w_latch) begin
        r_sh_ha <= bus.cfg_h_active;
        r_sh_hb <= bus.cfg_h_blank;
        r_sh_va <= bus.cfg_v_active;
        r_sh_vb <= bus.cfg_v_blank;
      end
      r_sel <= w_nxt_sel;
      r_bs  <= w_bstart;
      r_as  <= w_astart;
      r_fs  <= w_frame;
      r_vf  <= (w_nxt_state == VBLANK);
      if (w_cfg_bad) begin
        r_cfg_err <= 1'b1;
      end else if (w_cfg_good) begin
        r_cfg_err <= 1'b0;
      end
      // never stall on an empty source; just flag it
      if (w_nxt_state == IDLE) begin
        r_unf <= 1'b0;
      end else if (r_sel == SEL_ACTIVE && bus.active_fifo_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign bus.sched_stream_idle_sel = r_sel;
  assign bus.sched_blank_start     = r_bs;
  assign bus.sched_active_start    = r_as;
  assign bus.sched_vblank_flag     = r_vf;
  assign bus.sched_frame_start     = r_fs;
  assign bus.sched_cfg_err         = r_cfg_err;
  assign bus.sched_underflow_err   = r_unf;

`ifdef STREAM_SCHED_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // counts frame starts; held while idle, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.sched_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_stream_idle_scheduler.sv
// Self-checking bench for stream_idle_scheduler.
// Checks sched_frame_cnt too when STREAM_SCHED_FRAME_CNT_EN is defined.
module tb_stream_idle_scheduler;

  localparam int H_W = 16;
  localparam int V_W = 13;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_idle_scheduler_if #(.H_W(H_W), .V_W(V_W)) bus ();

  stream_idle_scheduler #(.H_W(H_W), .V_W(V_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] sel;
    logic       bs;
    logic       ast;
    logic       vf;
    logic       fs;
  } exp_t;

  typedef struct {
    int ha;
    int hb;
    int va;
    int vb;
    bit ok;
  } row_t;

  exp_t q[$];
  row_t rows[8];
  int   checks = 0;
  int   errors = 0;
  int   exp_fcnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_cfg(int ha, int hb, int va, int vb);
    bus.cfg_h_active = H_W'(ha);
    bus.cfg_h_blank  = H_W'(hb);
    bus.cfg_v_active = V_W'(va);
    bus.cfg_v_blank  = V_W'(vb);
  endtask

  // expected symbol stream of one whole frame
  task automatic push_frame(int ha, int hb, int va, int vb);
    exp_t e;
    for (int l = 0; l < vb; l++) begin
      for (int s = 0; s < hb + ha; s++) begin
        e.sel = 2'b01;
        e.bs  = (s == 0);
        e.ast = 1'b0;
        e.vf  = 1'b1;
        e.fs  = (l == 0 && s == 0);
        q.push_back(e);
      end
    end
    for (int l = 0; l < va; l++) begin
      for (int s = 0; s < hb; s++) begin
        e.sel = 2'b01;
        e.bs  = (s == 0);
        e.ast = 1'b0;
        e.vf  = 1'b0;
        e.fs  = 1'b0;
        q.push_back(e);
      end
      for (int s = 0; s < ha; s++) begin
        e.sel = 2'b10;
        e.bs  = 1'b0;
        e.ast = (s == 0);
        e.vf  = 1'b0;
        e.fs  = 1'b0;
        q.push_back(e);
      end
    end
  endtask

  task automatic pop_check(string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty at %0t", tag, $time);
      return;
    end
    e = q.pop_front();
    chk({tag, "_rec"},
        32'({bus.sched_stream_idle_sel, bus.sched_blank_start,
             bus.sched_active_start, bus.sched_vblank_flag,
             bus.sched_frame_start, bus.sched_cfg_err}),
        32'({e.sel, e.bs, e.ast, e.vf, e.fs, 1'b0}));
`ifdef STREAM_SCHED_FRAME_CNT_EN
    if (e.fs) begin
      exp_fcnt++;
      chk("frame_cnt", 32'(bus.sched_frame_cnt), 32'(exp_fcnt & 16'hFFFF));
    end
`endif
  endtask

  task automatic pop_n(string tag, int n);
    for (int i = 0; i < n; i++) begin
      tick();
      pop_check(tag);
    end
  endtask

  // checks every queued symbol, drops enable on the last one
  task automatic drain_and_stop(string tag);
    while (q.size() > 0) begin
      tick();
      pop_check(tag);
    end
    bus.cfg_stream_en = 1'b0;
    tick();
    chk({tag, "_stop_sel"}, 32'(bus.sched_stream_idle_sel), 32'd0);
    chk({tag, "_stop_vf"}, 32'(bus.sched_vblank_flag), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{ha: 8, hb: 4, va: 2, vb: 1, ok: 1'b1};
    rows[1] = '{ha: 1, hb: 4, va: 1, vb: 1, ok: 1'b1};
    rows[2] = '{ha: 3, hb: 5, va: 3, vb: 2, ok: 1'b1};
    rows[3] = '{ha: 8, hb: 3, va: 2, vb: 1, ok: 1'b0};
    rows[4] = '{ha: 2, hb: 6, va: 1, vb: 3, ok: 1'b1};
    rows[5] = '{ha: 0, hb: 4, va: 2, vb: 1, ok: 1'b0};
    rows[6] = '{ha: 8, hb: 4, va: 0, vb: 1, ok: 1'b0};
    rows[7] = '{ha: 8, hb: 4, va: 2, vb: 0, ok: 1'b0};

    rst = 1'b1;
    bus.cfg_stream_en = 1'b0;
    bus.active_fifo_empty = 1'b0;
    set_cfg(8, 4, 2, 1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_state",
        32'({bus.sched_stream_idle_sel, bus.sched_blank_start,
             bus.sched_active_start, bus.sched_vblank_flag,
             bus.sched_frame_start, bus.sched_cfg_err,
             bus.sched_underflow_err}), 32'd0);
`ifdef STREAM_SCHED_FRAME_CNT_EN
    chk("reset_frame_cnt", 32'(bus.sched_frame_cnt), 32'd0);
`endif

    // table: two frames for valid configs, error hold for invalid
    for (int r = 0; r < 8; r++) begin
      set_cfg(rows[r].ha, rows[r].hb, rows[r].va, rows[r].vb);
      if (rows[r].ok) begin
        push_frame(rows[r].ha, rows[r].hb, rows[r].va, rows[r].vb);
        push_frame(rows[r].ha, rows[r].hb, rows[r].va, rows[r].vb);
        bus.cfg_stream_en = 1'b1;
        drain_and_stop($sformatf("row%0d", r));
      end else begin
        bus.cfg_stream_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
          tick();
          chk($sformatf("row%0d_cfg_err", r), 32'(bus.sched_cfg_err), 32'd1);
          chk($sformatf("row%0d_idle_sel", r),
              32'(bus.sched_stream_idle_sel), 32'd0);
        end
        bus.cfg_stream_en = 1'b0;
        tick();
      end
    end

    // invalid h_blank, then fixed while still enabled
    set_cfg(8, 3, 2, 1);
    bus.cfg_stream_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hb3_cfg_err", 32'(bus.sched_cfg_err), 32'd1);
      chk("hb3_sel", 32'(bus.sched_stream_idle_sel), 32'd0);
    end
    set_cfg(8, 4, 2, 1);
    push_frame(8, 4, 2, 1);
    drain_and_stop("hb_fix");

    // disable at HACTIVE symbol 2 of 8: line still completes
    push_frame(8, 4, 2, 1);
    bus.cfg_stream_en = 1'b1;
    pop_n("midline", 12 + 4 + 3);
    bus.cfg_stream_en = 1'b0;
    pop_n("midline_tail", 5);
    q.delete();
    tick();
    chk("midline_idle_sel", 32'(bus.sched_stream_idle_sel), 32'd0);
    tick();
    chk("midline_idle_sel2", 32'(bus.sched_stream_idle_sel), 32'd0);

    // underflow: ignored in blank, sticky once set, cleared at idle
    push_frame(8, 4, 2, 1);
    push_frame(8, 4, 2, 1);
    bus.active_fifo_empty = 1'b1;
    bus.cfg_stream_en = 1'b1;
    pop_n("unf_vb", 12);
    bus.active_fifo_empty = 1'b0;
    chk("unf_blank", 32'(bus.sched_underflow_err), 32'd0);
    pop_n("unf_hb", 4 + 1);
    chk("unf_pre", 32'(bus.sched_underflow_err), 32'd0);
    bus.active_fifo_empty = 1'b1;
    pop_n("unf_hit", 1);
    bus.active_fifo_empty = 1'b0;
    chk("unf_set", 32'(bus.sched_underflow_err), 32'd1);
    while (q.size() > 0) begin
      tick();
      pop_check("unf_run");
    end
    chk("unf_sticky", 32'(bus.sched_underflow_err), 32'd1);
    bus.cfg_stream_en = 1'b0;
    tick();
    chk("unf_clear_idle", 32'(bus.sched_underflow_err), 32'd0);
    chk("unf_idle_sel", 32'(bus.sched_stream_idle_sel), 32'd0);

    // rst held 3 cycles mid-HACTIVE
    push_frame(8, 4, 2, 1);
    bus.cfg_stream_en = 1'b1;
    pop_n("prerst", 12 + 4 + 3);
    rst = 1'b1;
    tick();
    chk("midrst_outputs",
        32'({bus.sched_stream_idle_sel, bus.sched_blank_start,
             bus.sched_active_start, bus.sched_vblank_flag,
             bus.sched_frame_start, bus.sched_cfg_err,
             bus.sched_underflow_err}), 32'd0);
    tick();
    tick();
    chk("midrst_hold_sel", 32'(bus.sched_stream_idle_sel), 32'd0);
    q.delete();
    exp_fcnt = 0;

    // fresh frame after reset; h_active change lands next frame
    push_frame(8, 4, 2, 1);
    rst = 1'b0;
    pop_n("shadow_f1", 20);
    bus.cfg_h_active = H_W'(16);
    push_frame(16, 4, 2, 1);
    drain_and_stop("shadow");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
